// File: rtl/pattern_pkg.sv
// Shared definitions for the raster test-pattern generator:
// 16-entry colour palette, pattern mode encoding and box direction bit positions.
package pattern_pkg;

    typedef enum logic [1:0] {
        MODE_VBARS   = 2'd0,
        MODE_HBARS   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_WHITE   = 2'd3
    } mode_e;

    localparam int DIR_RIGHT = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_UP    = 3;

    localparam logic [23:0] COL_WHITE        = 24'hFFFFFF;
    localparam logic [23:0] COL_RED          = 24'hFF0000;
    localparam logic [23:0] COL_ORANGE       = 24'hFF8000;
    localparam logic [23:0] COL_YELLOW       = 24'hFFFF00;
    localparam logic [23:0] COL_GREEN_YELLOW = 24'h80FF00;
    localparam logic [23:0] COL_GREEN        = 24'h00FF00;
    localparam logic [23:0] COL_GREEN_BLUE   = 24'h00FF80;
    localparam logic [23:0] COL_TEAL         = 24'h008080;
    localparam logic [23:0] COL_BLUE_GREEN   = 24'h0080FF;
    localparam logic [23:0] COL_BLUE         = 24'h0000FF;
    localparam logic [23:0] COL_VIOLET       = 24'h8000FF;
    localparam logic [23:0] COL_PINK         = 24'hFF80C0;
    localparam logic [23:0] COL_FUCHSIA      = 24'hFF00FF;
    localparam logic [23:0] COL_DARK_GREY    = 24'h404040;
    localparam logic [23:0] COL_LIGHT_GREY   = 24'hC0C0C0;
    localparam logic [23:0] COL_BLACK        = 24'h000000;

    function automatic logic [23:0] palette_rgb(input logic [3:0] idx);
        palette_rgb = COL_BLACK;
        case (idx)
            4'd0:  palette_rgb = COL_WHITE;
            4'd1:  palette_rgb = COL_RED;
            4'd2:  palette_rgb = COL_ORANGE;
            4'd3:  palette_rgb = COL_YELLOW;
            4'd4:  palette_rgb = COL_GREEN_YELLOW;
            4'd5:  palette_rgb = COL_GREEN;
            4'd6:  palette_rgb = COL_GREEN_BLUE;
            4'd7:  palette_rgb = COL_TEAL;
            4'd8:  palette_rgb = COL_BLUE_GREEN;
            4'd9:  palette_rgb = COL_BLUE;
            4'd10: palette_rgb = COL_VIOLET;
            4'd11: palette_rgb = COL_PINK;
            4'd12: palette_rgb = COL_FUCHSIA;
            4'd13: palette_rgb = COL_DARK_GREY;
            4'd14: palette_rgb = COL_LIGHT_GREY;
            default: palette_rgb = COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/box_mover.sv
// Moving-box state: per-frame position stepping with clamping to the active area,
// and colour index stepping on each rising edge of dcolor.
module box_mover
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 1024,
    parameter int BOX_SIZE = 64
) (
    input  logic        rfr_clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        move_en,
    input  logic [3:0]  move_dir,
    input  logic [1:0]  speed,
    input  logic        dcolor,
    output logic [11:0] box_x,
    output logic [11:0] box_y,
    output logic [3:0]  color_idx
);

    localparam logic [11:0] X_MAX = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - BOX_SIZE);

    logic [12:0] step;
    logic [11:0] box_x_d, box_y_d;
    logic        dcolor_q;

    // Opposing bits both set or both clear leave the axis where it is.
    function automatic logic [11:0] step_axis(input logic [11:0] pos, input logic inc,
                                              input logic dec, input logic [12:0] stp,
                                              input logic [11:0] lim);
        logic [12:0] sum;
        sum = {1'b0, pos} + stp;
        step_axis = pos;
        if (inc && !dec)
            step_axis = (sum > {1'b0, lim}) ? lim : sum[11:0];
        else if (dec && !inc)
            step_axis = ({1'b0, pos} < stp) ? 12'd0 : pos - stp[11:0];
    endfunction

    always_comb begin
        step    = 13'd1 << speed;
        box_x_d = step_axis(box_x, move_dir[DIR_RIGHT], move_dir[DIR_LEFT], step, X_MAX);
        box_y_d = step_axis(box_y, move_dir[DIR_DOWN],  move_dir[DIR_UP],   step, Y_MAX);
    end

    always_ff @(posedge rfr_clk) begin
        if (reset) begin
            box_x     <= '0;
            box_y     <= '0;
            color_idx <= 4'd1;
            dcolor_q  <= 1'b0;
        end else begin
            dcolor_q <= dcolor;
            if (dcolor && !dcolor_q)
                color_idx <= color_idx + 4'd1;
            if (frame_start && move_en) begin
                box_x <= box_x_d;
                box_y <= box_y_d;
            end
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// Raster test-pattern generator: colour bars, checkerboard or white, one cycle behind the
// raster position. Define PATTERN_GEN_BOX_EN to add the movable colour box overlay.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 1024,
    parameter int NUM_BARS = 16,
    parameter int BOX_SIZE = 64
) (
    input  logic        rfr_clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [11:0] pixel_cnt,
    input  logic [11:0] line_cnt,
    input  logic        frame_start,
    input  logic [1:0]  mode,
    input  logic        move_en,
    input  logic [3:0]  move_dir,
    input  logic [1:0]  speed,
    input  logic        dcolor,
    output logic [7:0]  p_red,
    output logic [7:0]  p_green,
    output logic [7:0]  p_blue
);

    localparam logic [11:0] BAR_W    = 12'(H_ACTIVE / NUM_BARS);
    localparam logic [11:0] BAR_H    = 12'(V_ACTIVE / NUM_BARS);
    localparam logic [5:0]  LAST_BAR = 6'(NUM_BARS - 1);

    mode_e       mode_q;
    logic        armed;
    logic [5:0]  col_q, col_d, row_q, row_d;
    logic [11:0] col_bnd_q, col_bnd_d, row_bnd_q, row_bnd_d;
    logic [23:0] bg_rgb, pix_rgb;

    // Bar indices follow the raster incrementally; the last bar absorbs any remainder.
    always_comb begin
        col_d     = col_q;
        col_bnd_d = col_bnd_q;
        if (pixel_cnt == 12'd0) begin
            col_d     = '0;
            col_bnd_d = BAR_W;
        end else if (pixel_cnt == col_bnd_q && col_q != LAST_BAR) begin
            col_d     = col_q + 6'd1;
            col_bnd_d = col_bnd_q + BAR_W;
        end
    end

    always_comb begin
        row_d     = row_q;
        row_bnd_d = row_bnd_q;
        if (line_cnt == 12'd0) begin
            row_d     = '0;
            row_bnd_d = BAR_H;
        end else if (line_cnt == row_bnd_q && row_q != LAST_BAR) begin
            row_d     = row_q + 6'd1;
            row_bnd_d = row_bnd_q + BAR_H;
        end
    end

    always_comb begin
        bg_rgb = COL_WHITE;
        case (mode_q)
            MODE_VBARS:   bg_rgb = palette_rgb(col_d[3:0]);
            MODE_HBARS:   bg_rgb = palette_rgb(row_d[3:0]);
            MODE_CHECKER: bg_rgb = (pixel_cnt[5] ^ line_cnt[5]) ? COL_WHITE : COL_BLACK;
            default:      bg_rgb = COL_WHITE;
        endcase
    end

`ifdef PATTERN_GEN_BOX_EN
    logic [11:0] box_x, box_y;
    logic [3:0]  box_col;
    logic        in_box;

    box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE)
    ) u_box_mover (
        .rfr_clk     (rfr_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .move_en     (move_en),
        .move_dir    (move_dir),
        .speed       (speed),
        .dcolor      (dcolor),
        .box_x       (box_x),
        .box_y       (box_y),
        .color_idx   (box_col)
    );

    assign in_box = (pixel_cnt >= box_x) && ({1'b0, pixel_cnt} < {1'b0, box_x} + 13'(BOX_SIZE))
                 && (line_cnt >= box_y)  && ({1'b0, line_cnt}  < {1'b0, box_y} + 13'(BOX_SIZE));
    assign pix_rgb = in_box ? palette_rgb(box_col) : bg_rgb;
`else
    logic unused_box_in;
    assign unused_box_in = ^{move_en, move_dir, speed, dcolor};
    assign pix_rgb = bg_rgb;
`endif

    // After reset the output stays dark until a frame boundary re-arms it.
    always_ff @(posedge rfr_clk) begin
        if (reset) begin
            mode_q    <= MODE_VBARS;
            armed     <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            col_bnd_q <= BAR_W;
            row_bnd_q <= BAR_H;
            p_red     <= '0;
            p_green   <= '0;
            p_blue    <= '0;
        end else begin
            if (frame_start) begin
                mode_q <= mode_e'(mode);
                armed  <= 1'b1;
            end
            col_q     <= col_d;
            row_q     <= row_d;
            col_bnd_q <= col_bnd_d;
            row_bnd_q <= row_bnd_d;
            if (video_on && armed)
                {p_red, p_green, p_blue} <= pix_rgb;
            else
                {p_red, p_green, p_blue} <= '0;
        end
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 1024, active lines per frame.
REQ-003 SHALL have parameter NUM_BARS, default 16, bar count per axis, 1..64.
REQ-004 SHALL have parameter BOX_SIZE, default 64, box edge length in pixels.
REQ-005 SHALL have ports rfr_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports video_on  in  1, pixel_cnt  in  12, line_cnt  in  12, with current raster position from the timing generator.
REQ-008 SHALL have port frame_start  in  1  one-cycle pulse at start of each frame.
REQ-009 SHALL have port mode  in  2  pattern: 0 vertical bars, 1 horizontal bars, 2 checkerboard, 3 solid white.
REQ-010 SHALL have ports move_en  in  1, move_dir  in  4 (bit0 right, bit1 left, bit2 down, bit3 up), speed  in  2, dcolor  in  1.
REQ-011 SHALL have ports p_red, p_green, p_blue  out  8 each, registered.

Function
REQ-012 SHALL register outputs with exactly 1 cycle latency from pixel_cnt/line_cnt/video_on.
REQ-013 SHALL drive all outputs 0 when the registered video_on is 0.
REQ-014 SHALL latch mode only on frame_start; mid-frame mode changes have no effect until the next frame.
REQ-015 SHALL compute BAR_W = H_ACTIVE/NUM_BARS (BAR_H likewise from V_ACTIVE); the last bar absorbs any remainder.
REQ-016 SHALL track the bar index with a counter: cleared when pixel_cnt==0, incremented when pixel_cnt reaches the next bar boundary, saturating at NUM_BARS-1; no divider/modulo on pixel_cnt.
REQ-017 SHALL map bar index i to palette entry i mod 16 (16-entry palette: white, red, orange, yellow, green-yellow, green, green-blue, teal, blue-green, blue, violet, pink, fuchsia, dark grey, light grey, black).
REQ-018 SHALL in mode 2 output white when pixel_cnt[5]^line_cnt[5]==1, else black.
REQ-019 SHALL hold box position (box_x, box_y), updated only on frame_start with move_en=1.
REQ-020 SHALL step by 1<<speed (1, 2, 4, 8) pixels per frame per axis.
REQ-021 SHALL not move an axis when both its opposing direction bits are set or both clear.
REQ-022 SHALL clamp box_x to 0..H_ACTIVE-BOX_SIZE and box_y to 0..V_ACTIVE-BOX_SIZE; no wrap-around.
REQ-023 SHALL advance box color index (mod 16) once per rising edge of dcolor (edge-detected internally); a held dcolor advances once.
REQ-024 SHALL give box pixels priority over the background pattern in every mode.

Reset
REQ-025 SHALL on reset clear outputs to 0, bar counter to 0, latched mode to 0, box_x/box_y to 0, box color index to 1 (red), edge-detect register to 0.
REQ-026 SHALL on reset asserted mid-frame output 0 the following cycle and resume normal output from the next frame_start.

Configuration
REQ-027 SHALL with macro PATTERN_GEN_BOX_EN defined include the box overlay (REQ-019..REQ-024).
REQ-028 SHALL without PATTERN_GEN_BOX_EN omit all box logic; move_en, move_dir, speed, dcolor remain as ports and are ignored.

Structure
REQ-029 SHALL place the 16 palette colour constants (24-bit hex), the mode enum and the direction bit positions in package pattern_pkg.
REQ-030 SHALL implement box position, clamping and colour stepping in sub-module box_mover, instantiated only under PATTERN_GEN_BOX_EN.

Verification
REQ-031 SHALL verify: mode 0, defaults, line at video_on=1 -> pixel 0..79 white, 80..159 red, 1200..1279 black, each 1 cycle late.
REQ-032 SHALL verify: mode changed 0->2 mid-frame -> bars until frame_start, then pixel (32,0) white and (0,0) black.
REQ-033 SHALL verify: move_en=1, dir=right, speed=3, 200 frames -> box_x saturates at 1216, never exceeds.
REQ-034 SHALL verify: move_dir=0011 -> box_x unchanged over 5 frames; dcolor held high 10 cycles -> colour index 1->2 only.
REQ-035 SHALL verify: video_on=0 with any pattern -> all outputs 0; reset mid-line -> outputs 0 next cycle, box at (0,0).
REQ-036 SHALL verify: build without PATTERN_GEN_BOX_EN, toggle all box inputs -> output identical to pure background pattern.
